sequenciador_de_ritmo: RTL and testbench

//  Drives the pattern-list manager and judges the player. Generates the beat tempo as 1-cycle

---
 rtl/sequenciador_de_ritmo.sv | 209 ++++++++++++++++++++
 tb/tb_sequenciador_de_ritmo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_de_ritmo.sv
// ---------------------------------------------------------------------------
// sequenciador_de_ritmo
//   Rhythm-game referee. Generates the beat tempo that steps the pattern-list
//   manager, judges debounced button presses against the current one-hot
//   command inside a hit window, and keeps score, combo and lives. The game
//   ends when the list is exhausted (win) or lives reach zero (loss).
//
// Parameters
//   BEAT_CYCLES    clk cycles per beat (must exceed JANELA_CYCLES)
//   JANELA_CYCLES  hit window: first JANELA_CYCLES cycles of each beat
//   VIDAS          lives at game start (1..3)
//
// Ports
//   clk             in   1   system clock
//   rst             in   1   synchronous, active-high reset
//   iniciar         in   1   start/restart request (acted on in OCIOSO/FIM)
//   botoes          in   4   player buttons, debounced, active-high
//   comando         in   4   current command, one-hot (0 = rest)
//   fim_da_lista    in   1   pattern manager end-of-list flag
//   trocar_comando  out  1   1-cycle pulse stepping the pattern manager
//   rst_padroes     out  1   restarts the list, only with the priming pulse
//   estado          out  2   0 OCIOSO, 1 TOCANDO, 2 FIM
//   pontos          out  16  score, saturating
//   combo           out  8   consecutive hits, saturating
//   vidas           out  2   remaining lives
//   acerto          out  1   1-cycle pulse per hit
//   erro            out  1   1-cycle pulse per error
//   venceu          out  1   high in FIM when the list was completed alive
// ---------------------------------------------------------------------------
module sequenciador_de_ritmo #(
    parameter int BEAT_CYCLES   = 25_000_000,
    parameter int JANELA_CYCLES = 5_000_000,
    parameter int VIDAS         = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iniciar,
    input  logic [3:0]  botoes,
    input  logic [3:0]  comando,
    input  logic        fim_da_lista,
    output logic        trocar_comando,
    output logic        rst_padroes,
    output logic [1:0]  estado,
    output logic [15:0] pontos,
    output logic [7:0]  combo,
    output logic [1:0]  vidas,
    output logic        acerto,
    output logic        erro,
    output logic        venceu
);

    localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CW-1:0] ULTIMO    = CW'(BEAT_CYCLES - 1);
    localparam logic [CW-1:0] JANELA    = CW'(JANELA_CYCLES);
    localparam logic [1:0]    VIDAS_INI = 2'(VIDAS);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        TOCANDO = 2'd1,
        FIM     = 2'd2
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [CW-1:0]  cont_q, cont_d;
    logic [15:0]    pontos_q, pontos_d;
    logic [7:0]     combo_q, combo_d;
    logic [1:0]     vidas_q, vidas_d;
    logic           venceu_q, venceu_d;
    logic           julgado_q, julgado_d;
    logic [3:0]     botoes_q, botoes_d;

    logic [3:0]     press;
    logic           fim_beat;

    // Saturating score addition.
    function automatic logic [15:0] soma_sat16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {14'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Saturating combo increment.
    function automatic logic [7:0] inc_sat8(input logic [7:0] a);
        return (a == 8'hFF) ? a : a + 8'd1;
    endfunction

    // Points per hit grow with the combo held before the hit.
    function automatic logic [2:0] bonus(input logic [7:0] c);
        if (c < 8'd4)      return 3'd1;
        else if (c < 8'd8) return 3'd2;
        else               return 3'd4;
    endfunction

    assign press    = botoes & ~botoes_q;
    assign fim_beat = (cont_q == ULTIMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            cont_q    <= '0;
            pontos_q  <= '0;
            combo_q   <= '0;
            vidas_q   <= VIDAS_INI;
            venceu_q  <= 1'b0;
            julgado_q <= 1'b0;
            botoes_q  <= '0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            pontos_q  <= pontos_d;
            combo_q   <= combo_d;
            vidas_q   <= vidas_d;
            venceu_q  <= venceu_d;
            julgado_q <= julgado_d;
            botoes_q  <= botoes_d;
        end
    end

    always_comb begin
        estado_d       = estado_q;
        cont_d         = cont_q;
        pontos_d       = pontos_q;
        combo_d        = combo_q;
        vidas_d        = vidas_q;
        venceu_d       = venceu_q;
        julgado_d      = julgado_q;
        botoes_d       = botoes;
        trocar_comando = 1'b0;
        rst_padroes    = 1'b0;
        acerto         = 1'b0;
        erro           = 1'b0;

        case (estado_q)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    // Priming pulse: restart the list and step onto its first entry.
                    trocar_comando = 1'b1;
                    rst_padroes    = 1'b1;
                    pontos_d       = '0;
                    combo_d        = '0;
                    venceu_d       = 1'b0;
                    vidas_d        = VIDAS_INI;
                    cont_d         = '0;
                    julgado_d      = 1'b0;
                    // A button already held at start counts as a fresh press.
                    botoes_d       = '0;
                    estado_d       = TOCANDO;
                end
            end

            TOCANDO: begin
                cont_d = fim_beat ? '0 : cont_q + 1'b1;

                if ((press != 4'd0) && (comando != 4'd0)) begin
                    julgado_d = 1'b1;
                    if (!julgado_q && (press == comando) && (cont_q < JANELA))
                        acerto = 1'b1;
                    else
                        erro = 1'b1;
                end

                // Unjudged command at beat end is a miss; OR-ing keeps one erro
                // even when a late press lands in the same cycle.
                if (fim_beat && (comando != 4'd0) && !julgado_q)
                    erro = 1'b1;

                if (acerto) begin
                    combo_d  = inc_sat8(combo_q);
                    pontos_d = soma_sat16(pontos_q, bonus(combo_q));
                end

                if (erro) begin
                    combo_d = '0;
                    vidas_d = vidas_q - 2'd1;
                end

                if (erro && (vidas_q == 2'd1)) begin
                    estado_d = FIM;
                    venceu_d = 1'b0;
                end else if (fim_beat) begin
                    julgado_d = 1'b0;
                    if (fim_da_lista) begin
                        estado_d = FIM;
                        venceu_d = 1'b1;
                    end else begin
                        trocar_comando = 1'b1;
                    end
                end
            end

            default: estado_d = OCIOSO;
        endcase

        // Reset wins over any input-driven pulse in the same cycle.
        if (rst) begin
            trocar_comando = 1'b0;
            rst_padroes    = 1'b0;
            acerto         = 1'b0;
            erro           = 1'b0;
        end
    end

    assign estado = estado_q;
    assign pontos = pontos_q;
    assign combo  = combo_q;
    assign vidas  = vidas_q;
    assign venceu = venceu_q;

endmodule

// File: tb/tb_sequenciador_de_ritmo.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_de_ritmo
//   Directed bench for sequenciador_de_ritmo with BEAT_CYCLES=8,
//   JANELA_CYCLES=3, VIDAS=3. The stimulus queues the hand-computed
//   outcome of every pulse cycle; a monitor pops and compares whenever
//   trocar_comando, rst_padroes, acerto or erro is seen.
// ---------------------------------------------------------------------------
module tb_sequenciador_de_ritmo;

    logic        clk = 1'b0;
    logic        rst;
    logic        iniciar;
    logic [3:0]  botoes;
    logic [3:0]  comando;
    logic        fim_da_lista;
    logic        trocar_comando;
    logic        rst_padroes;
    logic [1:0]  estado;
    logic [15:0] pontos;
    logic [7:0]  combo;
    logic [1:0]  vidas;
    logic        acerto;
    logic        erro;
    logic        venceu;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        tr;
        logic        rp;
        logic        ac;
        logic        er;
        logic [1:0]  est;
        logic [15:0] pts;
        logic [7:0]  cmb;
        logic [1:0]  vid;
        logic        ven;
    } exp_t;

    exp_t sb[$];
    exp_t nada;

    sequenciador_de_ritmo #(
        .BEAT_CYCLES  (8),
        .JANELA_CYCLES(3),
        .VIDAS        (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .iniciar       (iniciar),
        .botoes        (botoes),
        .comando       (comando),
        .fim_da_lista  (fim_da_lista),
        .trocar_comando(trocar_comando),
        .rst_padroes   (rst_padroes),
        .estado        (estado),
        .pontos        (pontos),
        .combo         (combo),
        .vidas         (vidas),
        .acerto        (acerto),
        .erro          (erro),
        .venceu        (venceu)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input logic tr, input logic rp, input logic ac, input logic er,
                                input logic [1:0] est, input logic [15:0] pts,
                                input logic [7:0] cmb, input logic [1:0] vid, input logic ven);
        exp_t e;
        e.tr = tr; e.rp = rp; e.ac = ac; e.er = er;
        e.est = est; e.pts = pts; e.cmb = cmb; e.vid = vid; e.ven = ven;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full beat starting at counter 0; optional single press at cycle pat.
    task automatic beat(input logic [3:0] cmd, input int pat, input logic [3:0] pval,
                        input logic fim, input logic hp, input exp_t ep,
                        input logic he, input exp_t ee);
        for (int c = 0; c < 8; c++) begin
            comando      = cmd;
            fim_da_lista = fim;
            botoes       = (c == pat) ? pval : 4'b0000;
            if (hp && c == pat) sb.push_back(ep);
            if (he && c == 7)   sb.push_back(ee);
            tick();
        end
        botoes = 4'b0000;
    endtask

    // Monitor: pulses sampled mid-cycle, registered outputs just after the edge.
    always begin
        exp_t got;
        exp_t e;
        @(negedge clk);
        if (trocar_comando === 1'b1 || rst_padroes === 1'b1 ||
            acerto === 1'b1 || erro === 1'b1) begin
            got.tr = trocar_comando; got.rp = rst_padroes;
            got.ac = acerto;         got.er = erro;
            @(posedge clk);
            #1;
            got.est = estado; got.pts = pontos; got.cmb = combo;
            got.vid = vidas;  got.ven = venceu;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: got tr=%0d rp=%0d ac=%0d er=%0d, expected no event",
                         got.tr, got.rp, got.ac, got.er);
            end else begin
                e = sb.pop_front();
                chk("ev_trocar",  got.tr,  e.tr);
                chk("ev_rst_pad", got.rp,  e.rp);
                chk("ev_acerto",  got.ac,  e.ac);
                chk("ev_erro",    got.er,  e.er);
                chk("ev_estado",  got.est, e.est);
                chk("ev_pontos",  got.pts, e.pts);
                chk("ev_combo",   got.cmb, e.cmb);
                chk("ev_vidas",   got.vid, e.vid);
                chk("ev_venceu",  got.ven, e.ven);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nada         = '0;
        rst          = 1'b1;
        iniciar      = 1'b0;
        botoes       = 4'b0000;
        comando      = 4'b0000;
        fim_da_lista = 1'b0;
        tick();
        tick();

        // Reset overrides a start request.
        iniciar = 1'b1;
        @(negedge clk);
        chk("rst_no_trocar", trocar_comando, 0);
        chk("rst_no_rstpad", rst_padroes, 0);
        tick();
        rst     = 1'b0;
        iniciar = 1'b0;
        @(negedge clk);
        chk("rst_estado", estado, 0);
        chk("rst_pontos", pontos, 0);
        chk("rst_combo",  combo, 0);
        chk("rst_vidas",  vidas, 3);
        chk("rst_venceu", venceu, 0);
        tick();

        // Start.
        iniciar = 1'b1;
        sb.push_back(mk(1, 1, 0, 0, 2'd1, 16'd0, 8'd0, 2'd3, 0));
        tick();
        iniciar = 1'b0;

        // Five hits: pontos 1,2,3,4,6.
        beat(4'b0010, 1, 4'b0010, 0, 1, mk(0,0,1,0,2'd1,16'd1,8'd1,2'd3,0), 1, mk(1,0,0,0,2'd1,16'd1,8'd1,2'd3,0));
        iniciar = 1'b1;  // ignored while playing
        beat(4'b0001, 0, 4'b0001, 0, 1, mk(0,0,1,0,2'd1,16'd2,8'd2,2'd3,0), 1, mk(1,0,0,0,2'd1,16'd2,8'd2,2'd3,0));
        iniciar = 1'b0;
        beat(4'b1000, 2, 4'b1000, 0, 1, mk(0,0,1,0,2'd1,16'd3,8'd3,2'd3,0), 1, mk(1,0,0,0,2'd1,16'd3,8'd3,2'd3,0));
        beat(4'b0100, 1, 4'b0100, 0, 1, mk(0,0,1,0,2'd1,16'd4,8'd4,2'd3,0), 1, mk(1,0,0,0,2'd1,16'd4,8'd4,2'd3,0));
        beat(4'b0010, 2, 4'b0010, 0, 1, mk(0,0,1,0,2'd1,16'd6,8'd5,2'd3,0), 1, mk(1,0,0,0,2'd1,16'd6,8'd5,2'd3,0));

        // Late press: erro, and the beat end stays quiet apart from trocar.
        beat(4'b0010, 5, 4'b0010, 0, 1, mk(0,0,0,1,2'd1,16'd6,8'd0,2'd2,0), 1, mk(1,0,0,0,2'd1,16'd6,8'd0,2'd2,0));
        // Press during a rest beat is ignored.
        beat(4'b0000, 1, 4'b0100, 0, 0, nada, 1, mk(1,0,0,0,2'd1,16'd6,8'd0,2'd2,0));
        // Hit with combo 0.
        beat(4'b0100, 0, 4'b0100, 0, 1, mk(0,0,1,0,2'd1,16'd7,8'd1,2'd2,0), 1, mk(1,0,0,0,2'd1,16'd7,8'd1,2'd2,0));
        // Last entry: hit, then list end -> win, no trocar pulse.
        beat(4'b0001, 2, 4'b0001, 1, 1, mk(0,0,1,0,2'd1,16'd8,8'd2,2'd2,0), 0, nada);
        fim_da_lista = 1'b0;
        @(negedge clk);
        chk("win_estado", estado, 2);
        chk("win_venceu", venceu, 1);
        chk("win_vidas",  vidas, 2);

        // Presses in FIM change nothing.
        for (int i = 0; i < 6; i++) begin
            botoes = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        botoes = 4'b0000;
        @(negedge clk);
        chk("fim_pontos", pontos, 8);
        chk("fim_combo",  combo, 2);
        chk("fim_estado", estado, 2);
        tick();

        // Restart from FIM and lose all lives by misses.
        iniciar = 1'b1;
        sb.push_back(mk(1, 1, 0, 0, 2'd1, 16'd0, 8'd0, 2'd3, 0));
        tick();
        iniciar = 1'b0;
        beat(4'b0100, -1, 4'b0000, 0, 0, nada, 1, mk(1,0,0,1,2'd1,16'd0,8'd0,2'd2,0));
        beat(4'b0100, -1, 4'b0000, 0, 0, nada, 1, mk(1,0,0,1,2'd1,16'd0,8'd0,2'd1,0));
        beat(4'b0100, -1, 4'b0000, 0, 0, nada, 1, mk(0,0,0,1,2'd2,16'd0,8'd0,2'd0,0));
        @(negedge clk);
        chk("lose_estado", estado, 2);
        chk("lose_venceu", venceu, 0);
        tick();

        // Restart, score once, then reset mid-beat over a would-be erro press.
        iniciar = 1'b1;
        sb.push_back(mk(1, 1, 0, 0, 2'd1, 16'd0, 8'd0, 2'd3, 0));
        tick();
        iniciar = 1'b0;
        comando = 4'b1000;
        botoes  = 4'b0000;
        tick();
        botoes = 4'b1000;
        sb.push_back(mk(0, 0, 1, 0, 2'd1, 16'd1, 8'd1, 2'd3, 0));
        tick();
        botoes = 4'b0000;
        tick();
        rst    = 1'b1;
        botoes = 4'b1000;
        @(negedge clk);
        chk("midrst_erro",   erro, 0);
        chk("midrst_trocar", trocar_comando, 0);
        tick();
        rst     = 1'b0;
        botoes  = 4'b0000;
        comando = 4'b0000;
        @(negedge clk);
        chk("midrst_estado", estado, 0);
        chk("midrst_pontos", pontos, 0);
        chk("midrst_combo",  combo, 0);
        chk("midrst_vidas",  vidas, 3);
        for (int i = 0; i < 4; i++) tick();

        chk("queue_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
